// File: rtl/mm_pkg.sv
// mm_pkg: shared types for the matrix-multiply MAC sequencer.
//   state_e  - sequencer FSM states
//   track_t  - one tracking-pipe entry following a product through the multiplier
//   clog2_min1 - ceil(log2(n)) clamped to at least 1, for index/address widths
package mm_pkg;

    // Widest element address a tracking entry can carry (DIM up to 256).
    localparam int ADDR_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  first_k;
        logic                  last_k;
        logic [ADDR_MAX_W-1:0] addr;
    } track_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_valid_pipe.sv
// mm_valid_pipe: fixed-depth shift register of tracking entries.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   in_e       : entry loaded into stage 0 every cycle
//   out_e      : tail entry (stage DEPTH-1)
module mm_valid_pipe
    import mm_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic   clk,
    input  logic   rst_n,
    input  track_t in_e,
    output track_t out_e
);

    track_t [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], in_e};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign out_e = pipe_q[DEPTH-1];

endmodule

// File: rtl/mm_mac_sequencer.sv
// mm_mac_sequencer: drives one shared pipelined multiplier to compute C = A x B
// for DIM x DIM unsigned matrices, one (i,j,k) product issued per cycle.
//   start/busy/done      : run control (start sampled only in IDLE)
//   a_rd_en/a_addr/a_data: A memory port, address i*DIM+k, data one cycle later
//   b_rd_en/b_addr/b_data: B memory port, address k*DIM+j
//   mul_a/mul_b/mul_p    : multiplier operands (pass-through) and product
//   c_we/c_addr/c_data   : registered C element write
//   cycle_cnt            : busy-cycle counter, present only with MM_PERF_CNT_EN
module mm_mac_sequencer
    import mm_pkg::*;
#(
    parameter int DIM     = 4,
    parameter int DW      = 32,
    parameter int MUL_LAT = 6,
    parameter int AW      = clog2_min1(DIM * DIM),
    parameter int ACC_W   = 2 * DW + $clog2(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a_rd_en,
    output logic [AW-1:0]    a_addr,
    output logic             b_rd_en,
    output logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    a_data,
    input  logic [DW-1:0]    b_data,
    output logic [DW-1:0]    mul_a,
    output logic [DW-1:0]    mul_b,
    input  logic [2*DW-1:0]  mul_p,
    output logic             c_we,
    output logic [AW-1:0]    c_addr,
    output logic [ACC_W-1:0] c_data
`ifdef MM_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt
`endif
);

    localparam int            CW        = clog2_min1(DIM);
    localparam logic [CW-1:0] IDX_LAST  = CW'(DIM - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DIM * DIM - 1);

    function automatic logic [AW-1:0] elem(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * DIM + int'(c));
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              c_we_q, c_we_d;
    logic [AW-1:0]     c_addr_q, c_addr_d;
    logic [ACC_W-1:0]  c_data_q, c_data_d;
    track_t            issue_e, tail_e;
    logic [ACC_W-1:0]  p_ext, mac;

    // ---------------- issue FSM and index counters ----------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                // k innermost, then j, then i; counters return to 0 after the last triple
                if (k_q == IDX_LAST) begin
                    k_d = '0;
                    if (j_q == IDX_LAST) begin
                        j_d = '0;
                        if (i_q == IDX_LAST) begin
                            i_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            // C is written in address order, so the final element marks the end
            DRAIN: if (c_we_q && c_addr_q == ADDR_LAST) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_e = '0;
        if (state_q == ISSUE) begin
            issue_e.valid   = 1'b1;
            issue_e.first_k = (k_q == '0);
            issue_e.last_k  = (k_q == IDX_LAST);
            issue_e.addr    = ADDR_MAX_W'(elem(i_q, j_q));
        end
    end

    // Stage 0 lines up with the read data; the tail lines up with mul_p.
    mm_valid_pipe #(.DEPTH(1 + MUL_LAT)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_e  (issue_e),
        .out_e (tail_e)
    );

    // ---------------- accumulate and write back ----------------
    always_comb begin
        p_ext    = ACC_W'(mul_p);
        mac      = tail_e.first_k ? p_ext : acc_q + p_ext;
        acc_d    = acc_q;
        c_we_d   = 1'b0;
        c_addr_d = c_addr_q;
        c_data_d = c_data_q;
        if (tail_e.valid) begin
            acc_d = mac;
            if (tail_e.last_k) begin
                c_we_d   = 1'b1;
                c_addr_d = AW'(tail_e.addr);
                c_data_d = mac;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            c_we_q   <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            c_we_q   <= c_we_d;
            c_addr_q <= c_addr_d;
            c_data_q <= c_data_d;
        end
    end

    assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign a_rd_en = (state_q == ISSUE);
    assign b_rd_en = (state_q == ISSUE);
    assign a_addr  = elem(i_q, k_q);
    assign b_addr  = elem(k_q, j_q);
    assign mul_a   = a_data;
    assign mul_b   = b_data;
    assign c_we    = c_we_q;
    assign c_addr  = c_addr_q;
    assign c_data  = c_data_q;

`ifdef MM_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == IDLE && start)       cyc_cnt_d = '0;
        else if (busy && cyc_cnt_q != '1)   cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt_q <= '0;
        else        cyc_cnt_q <= cyc_cnt_d;
    end

    assign cycle_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_mm_mac_sequencer.sv
// Bench for mm_mac_sequencer: three instances (DIM=4/LAT=6, DIM=2/LAT=6,
// DIM=1/LAT=1) with behavioural operand memories and multiplier pipes.
// Expected C writes are queued when a run is set up and checked as they appear.
module tb_mm_mac_sequencer;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [65:0] data;
    } exp_t;

    exp_t   q4[$], q2[$], q1[$];
    longint first_v[3], last_v[3];
    int     wr_v[3];

    logic [2:0] start_v, busy_v, done_v, cwe_v;

    // ---- instance 0: DIM=4, MUL_LAT=6 ----
    logic [31:0] mem_a4[16], mem_b4[16];
    logic        are4, bre4;
    logic [3:0]  aa4, ba4, ca4;
    logic [31:0] ad4, bd4, mua4, mub4;
    logic [63:0] pp4[6];
    logic [63:0] mp4;
    logic [65:0] cd4;
    // ---- instance 1: DIM=2, MUL_LAT=6 ----
    logic [31:0] mem_a2[4], mem_b2[4];
    logic        are2, bre2;
    logic [1:0]  aa2, ba2, ca2;
    logic [31:0] ad2, bd2, mua2, mub2;
    logic [63:0] pp2[6];
    logic [63:0] mp2;
    logic [64:0] cd2;
    // ---- instance 2: DIM=1, MUL_LAT=1 ----
    logic [31:0] mem_a1[1], mem_b1[1];
    logic        are1, bre1;
    logic [0:0]  aa1, ba1, ca1;
    logic [31:0] ad1, bd1, mua1, mub1;
    logic [63:0] pp1[1];
    logic [63:0] mp1;
    logic [63:0] cd1;
`ifdef MM_PERF_CNT_EN
    logic [31:0] cc4, cc2, cc1;
`endif

    always @(posedge clk) begin
        if (are4) ad4 <= mem_a4[aa4];
        if (bre4) bd4 <= mem_b4[ba4];
        if (are2) ad2 <= mem_a2[aa2];
        if (bre2) bd2 <= mem_b2[ba2];
        if (are1) ad1 <= mem_a1[aa1];
        if (bre1) bd1 <= mem_b1[ba1];
        pp4[0] <= 64'(mua4) * 64'(mub4);
        pp2[0] <= 64'(mua2) * 64'(mub2);
        pp1[0] <= 64'(mua1) * 64'(mub1);
        for (int s = 1; s < 6; s++) begin
            pp4[s] <= pp4[s-1];
            pp2[s] <= pp2[s-1];
        end
    end
    assign mp4 = pp4[5];
    assign mp2 = pp2[5];
    assign mp1 = pp1[0];

    mm_mac_sequencer #(.DIM(4), .DW(32), .MUL_LAT(6)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .a_rd_en(are4), .a_addr(aa4), .b_rd_en(bre4), .b_addr(ba4),
        .a_data(ad4), .b_data(bd4), .mul_a(mua4), .mul_b(mub4), .mul_p(mp4),
        .c_we(cwe_v[0]), .c_addr(ca4), .c_data(cd4)
`ifdef MM_PERF_CNT_EN
        , .cycle_cnt(cc4)
`endif
    );

    mm_mac_sequencer #(.DIM(2), .DW(32), .MUL_LAT(6)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .a_rd_en(are2), .a_addr(aa2), .b_rd_en(bre2), .b_addr(ba2),
        .a_data(ad2), .b_data(bd2), .mul_a(mua2), .mul_b(mub2), .mul_p(mp2),
        .c_we(cwe_v[1]), .c_addr(ca2), .c_data(cd2)
`ifdef MM_PERF_CNT_EN
        , .cycle_cnt(cc2)
`endif
    );

    mm_mac_sequencer #(.DIM(1), .DW(32), .MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .a_rd_en(are1), .a_addr(aa1), .b_rd_en(bre1), .b_addr(ba1),
        .a_data(ad1), .b_data(bd1), .mul_a(mua1), .mul_b(mub1), .mul_p(mp1),
        .c_we(cwe_v[2]), .c_addr(ca1), .c_data(cd1)
`ifdef MM_PERF_CNT_EN
        , .cycle_cnt(cc1)
`endif
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0:       return q4.size();
            1:       return q2.size();
            default: return q1.size();
        endcase
    endfunction

    task automatic push(input int id, input int addr, input logic [65:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        case (id)
            0:       q4.push_back(e);
            1:       q2.push_back(e);
            default: q1.push_back(e);
        endcase
    endtask

    // Compare one instance's C port against the head of its scoreboard.
    task automatic mon(input int id, input logic we, input int addr, input logic [65:0] data);
        exp_t e;
        int   sz;
        if (we) begin
            sz = qsize(id);
            if (first_v[id] < 0) first_v[id] = cyc;
            last_v[id] = cyc;
            wr_v[id]++;
            chk($sformatf("inst%0d_we_expected", id), 66'(we), 66'(sz > 0));
            if (sz > 0) begin
                case (id)
                    0:       e = q4.pop_front();
                    1:       e = q2.pop_front();
                    default: e = q1.pop_front();
                endcase
                chk($sformatf("inst%0d_c_addr", id), 66'(addr), 66'(e.addr));
                chk($sformatf("inst%0d_c_data", id), data, e.data);
            end
        end
    endtask

    // Every negedge wait goes through here so no C write escapes the scoreboard.
    task automatic tick();
        @(negedge clk);
        mon(0, cwe_v[0], int'(ca4), 66'(cd4));
        mon(1, cwe_v[1], int'(ca2), 66'(cd2));
        mon(2, cwe_v[2], int'(ca1), 66'(cd1));
    endtask

    task automatic run(input int id, input string tag, input int exp_done, input int exp_first);
        longint t0;
        bit     got;
        first_v[id] = -1;
        tick();
        start_v[id] = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        start_v[id] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            tick();
            if (done_v[id]) got = 1'b1;
        end
        chk({tag, "_done_seen"},   66'(got), 66'(1));
        chk({tag, "_done_lat"},    66'(cyc - t0), 66'(exp_done));
        chk({tag, "_first_we"},    66'(first_v[id] - t0), 66'(exp_first));
        chk({tag, "_done_gap"},    66'(cyc - last_v[id]), 66'(1));
        chk({tag, "_all_written"}, 66'(qsize(id)), 66'(0));
        chk({tag, "_busy_low"},    66'(busy_v[id]), 66'(0));
    endtask

    task automatic load_ident4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem_a4[r*4+c] = (r == c) ? 32'd1 : 32'd0;
                mem_b4[r*4+c] = 32'(r*4 + c);
                push(0, r*4 + c, 66'(r*4 + c));
            end
    endtask

    initial begin
        int  base;
        bit  got;
        rst_n   = 1'b0;
        start_v = '0;
        wr_v    = '{0, 0, 0};
        first_v = '{-1, -1, -1};
        last_v  = '{0, 0, 0};

        // ---- reset state ----
        #12;
        chk("rst_busy",  66'(busy_v), 66'(0));
        chk("rst_done",  66'(done_v), 66'(0));
        chk("rst_c_we",  66'(cwe_v), 66'(0));
        chk("rst_rd_en", 66'({are4, bre4, are2, bre2, are1, bre1}), 66'(0));
        chk("rst_addr",  66'({aa4, ba4, ca4}), 66'(0));
        chk("rst_c_data", cd4, 66'(0));
`ifdef MM_PERF_CNT_EN
        chk("rst_cycle_cnt", 66'(cc4), 66'(0));
`endif
        tick();
        rst_n = 1'b1;

        // ---- DIM=4 identity x B ----
        load_ident4();
        run(0, "t1_ident", 72, 11);

        // ---- DIM=4 all-ones: full-width accumulation ----
        for (int n = 0; n < 16; n++) begin
            mem_a4[n] = 32'hFFFF_FFFF;
            mem_b4[n] = 32'hFFFF_FFFF;
            push(0, n, 66'h3_FFFF_FFF8_0000_0004);
        end
        run(0, "t2_ones", 72, 11);

        // ---- DIM=2 small matrices ----
        mem_a2 = '{32'd1, 32'd2, 32'd3, 32'd4};
        mem_b2 = '{32'd5, 32'd6, 32'd7, 32'd8};
        push(1, 0, 66'd19); push(1, 1, 66'd22); push(1, 2, 66'd43); push(1, 3, 66'd50);
        run(1, "t3_2x2", 16, 9);

        // ---- start asserted every cycle while busy: one run only ----
        base = wr_v[1];
        push(1, 0, 66'd19); push(1, 1, 66'd22); push(1, 2, 66'd43); push(1, 3, 66'd50);
        tick();
        start_v[1] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            tick();
            if (done_v[1]) begin
                got = 1'b1;
                start_v[1] = 1'b0;
            end
        end
        chk("t4a_done_seen", 66'(got), 66'(1));
        repeat (12) tick();
        chk("t4a_write_count", 66'(wr_v[1] - base), 66'(4));
        chk("t4a_busy_low",    66'(busy_v[1]), 66'(0));

        // ---- start held through DONE: second run accepted in IDLE ----
        base = wr_v[1];
        for (int r = 0; r < 2; r++) begin
            push(1, 0, 66'd19); push(1, 1, 66'd22); push(1, 2, 66'd43); push(1, 3, 66'd50);
        end
        tick();
        start_v[1] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            tick();
            if (done_v[1]) got = 1'b1;
        end
        chk("t4b_done1_seen", 66'(got), 66'(1));
        tick();
        chk("t4b_idle_busy", 66'(busy_v[1]), 66'(0));
        tick();
        chk("t4b_rerun_busy", 66'(busy_v[1]), 66'(1));
        start_v[1] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            tick();
            if (done_v[1]) got = 1'b1;
        end
        chk("t4b_done2_seen",  66'(got), 66'(1));
        chk("t4b_write_count", 66'(wr_v[1] - base), 66'(8));

        // ---- reset mid-ISSUE aborts, then a clean rerun ----
        tick();
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (10) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_busy",  66'(busy_v[0]), 66'(0));
        chk("t5_async_rd_en", 66'({are4, bre4}), 66'(0));
        chk("t5_async_addr",  66'({aa4, ba4}), 66'(0));
        chk("t5_async_c_we",  66'(cwe_v[0]), 66'(0));
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("t5_no_we_after_rst", 66'(cwe_v[0]), 66'(0));
            if (n == 1) rst_n = 1'b1;
        end
        chk("t5_stays_idle", 66'(busy_v[0]), 66'(0));
        load_ident4();
        run(0, "t5_rerun", 72, 11);

        // ---- DIM=1, MUL_LAT=1 ----
        mem_a1[0] = 32'd7;
        mem_b1[0] = 32'd9;
        push(2, 0, 66'd63);
        run(2, "t6_dim1", 4, 3);
`ifdef MM_PERF_CNT_EN
        chk("t6_cycle_cnt", 66'(cc1), 66'(4));
        repeat (3) tick();
        chk("t6_cycle_cnt_hold", 66'(cc1), 66'(4));
`endif

        repeat (4) tick();
        chk("end_queues_empty", 66'(q4.size() + q2.size() + q1.size()), 66'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
